// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: sequences the deserialiser, checks each frame, buffers bytes in a FWFT FIFO.
// Optional macro UART_RX_PARITY_CHECK_EN enables the parity check; when undefined, parity is ignored.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                          baud_clk_rx,
    input  logic                          rst,
    input  logic [10:0]                   parallel_data_rx,
    input  logic                          active_flag_rx,
    input  logic                          received_flag,
    input  logic                          rx_enable,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic                          err_clear,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, RECV, CHECK} state_t;

    state_t         state_q, state_d;
    logic [10:0]    frame_q;
    logic           capture_en;
    logic           in_check;
    logic [7:0]     push_data;
    logic           stop_bad;
    logic           par_bad;
    logic           fifo_full;
    logic           pop;
    logic           push;
    logic           frame_set;
    logic           parity_set;
    logic           overrun_set;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic [7:0]     last_q;

    always_ff @(posedge baud_clk_rx or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        capture_en = 1'b0;
        in_check   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_enable) state_d = ARMED;
            end
            ARMED: begin
                if (!rx_enable)          state_d = IDLE;
                else if (active_flag_rx) state_d = RECV;
            end
            RECV: begin
                // rx_enable is deliberately ignored here so a started frame always completes
                if (!active_flag_rx) begin
                    capture_en = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                in_check = 1'b1;
                state_d  = rx_enable ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk_rx or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else if (capture_en) begin
            frame_q <= parallel_data_rx;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            push_data[i] = frame_q[9-i];
        end
    end

    assign stop_bad = ~frame_q[0];
`ifdef UART_RX_PARITY_CHECK_EN
    assign par_bad = ((^frame_q[9:1]) != PARITY_ODD);
    logic unused_bits;
    assign unused_bits = received_flag ^ frame_q[10];
`else
    assign par_bad = 1'b0;
    logic unused_bits;
    assign unused_bits = received_flag ^ frame_q[10] ^ frame_q[1] ^ PARITY_ODD;
`endif

    assign rx_valid    = (count_q != '0);
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign pop         = rx_valid & rx_ready;
    assign frame_set   = in_check & stop_bad;
    assign parity_set  = in_check & ~stop_bad & par_bad;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    assign push        = in_check & ~stop_bad & ~par_bad & (~fifo_full | pop);
    assign overrun_set = in_check & ~stop_bad & ~par_bad & fifo_full & ~pop;

    always_ff @(posedge baud_clk_rx) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge baud_clk_rx or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_data    = rx_valid ? mem[rd_ptr] : last_q;
    assign fifo_count = count_q;
    assign busy       = (state_q == RECV) || (state_q == CHECK);

    // Setting takes precedence over a simultaneous clear
    always_ff @(posedge baud_clk_rx or negedge rst) begin
        if (!rst) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set   | (frame_err   & ~err_clear);
            parity_err  <= parity_set  | (parity_err  & ~err_clear);
            overrun_err <= overrun_set | (overrun_err & ~err_clear);
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver. It sequences the 11-bit SIPO deserialiser by watching its activity flag and capturing each completed frame. It checks stop and parity bits, then pushes valid data bytes into a small first-word-fall-through FIFO. The consumer drains the FIFO through a valid/ready handshake, and sticky error flags report framing, parity and overrun faults.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the receive FIFO; must be a power of 2 and at least 2.
PARITY_ODD, 0, selects the parity sense: 0 = even parity, 1 = odd parity.

Ports:
baud_clk_rx  in  1  baud clock; the same clock that drives the deserialiser.
rst  in  1  asynchronous, active-low reset.
parallel_data_rx  in  11  frame from the deserialiser. [10]=start, [9:2]=D0..D7 (D0 at [9]), [1]=parity, [0]=stop.
active_flag_rx  in  1  high while the deserialiser is shifting in a frame.
received_flag  in  1  deserialiser idle/complete indication; status only, not used for sequencing.
rx_enable  in  1  high = accept frames; low = ignore frames.
rx_data  out  8  FIFO head byte; bit i = frame bit [9-i].
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer accepts the head entry when rx_valid & rx_ready.
err_clear  in  1  one-cycle pulse that clears all sticky error flags.
frame_err  out  1  sticky; a captured frame had stop bit = 0.
parity_err  out  1  sticky; a captured frame had bad parity.
overrun_err  out  1  sticky; a good frame was dropped because the FIFO was full.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
busy  out  1  high in the RECV or CHECK state.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE and the FIFO is emptied.
  - rx_data=0, rx_valid=0, fifo_count=0, busy=0.
  - frame_err, parity_err and overrun_err are all 0.
  - Reset mid-frame drops the partial frame with no error recorded.
- FSM states and transitions:
  - IDLE: if rx_enable=1, go to ARMED.
  - ARMED: if rx_enable=0, go to IDLE. Otherwise, if active_flag_rx=1, go to RECV. The check is on the level, so a frame that started while the FSM was in CHECK is still caught.
  - RECV: stay while active_flag_rx=1. On the first cycle with active_flag_rx=0, latch parallel_data_rx into frame_q and go to CHECK.
  - CHECK (one cycle): evaluate frame_q in priority order; then go to ARMED, or to IDLE if rx_enable=0.
    1. frame_q[0]=0: set frame_err and drop the frame.
    2. Else if parity fails: set parity_err and drop the frame. Parity passes when XOR(frame_q[9:1]) equals PARITY_ODD.
    3. Else if the FIFO is full and no pop occurs this cycle: set overrun_err and drop the frame.
    4. Else push frame_q[9:2], with bit order reversed into rx_data order.
- rx_enable=0 during RECV does not abort the frame. The frame completes and is checked and pushed normally; the FSM then goes to IDLE.
- Latency: with the FIFO empty, let T be the first cycle with active_flag_rx=0 in RECV. CHECK occurs at T+1 and rx_valid is high at T+2.
- FIFO rules:
  - First-word fall-through: rx_data always shows the head entry and is valid whenever rx_valid=1.
  - A pop occurs when rx_valid & rx_ready.
  - Pop while empty: ignored.
  - Push and pop in the same cycle: fifo_count is unchanged, and a push while full is allowed.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- rx_data is held at its last value while the FIFO is empty.
- Sticky errors:
  - Each error flag is set in CHECK and cleared by err_clear.
  - If err_clear and a new error of the same type occur in the same cycle, the set wins.
  - Error flags never block further reception.

Optional Feature:
UART_RX_PARITY_CHECK_EN.
- Defined: parity check step 2 is active as described above.
- Undefined: frame_q[1] is ignored, parity_err is tied to 0, and frames with stop=1 are pushed regardless of parity.

Test Plan:
- Good frame (even parity): rx_enable=1, FIFO empty; drive active_flag_rx high for 11 cycles, then low, with parallel_data_rx=11'h2A9 → rx_valid=1 at T+2, rx_data=8'h55, fifo_count=1, no error flag set; rx_ready=1 for one cycle → rx_valid=0, fifo_count=0.
- Framing error: same stimulus with 11'h2A8 → frame_err=1 from T+2, no push; err_clear pulse → frame_err=0.
- Parity error: 11'h2AB → parity_err=1 with no push when UART_RX_PARITY_CHECK_EN is defined; rx_data=8'h55 pushed with parity_err=0 when it is undefined.
- Overrun: FIFO_DEPTH=4, rx_ready=0, five good frames with data 01,02,03,04,05 → fifo_count=4, overrun_err=1; draining returns 01,02,03,04 in that order.
- Full plus simultaneous pop: FIFO full, rx_ready=1 held in the CHECK cycle of a good frame 8'hA5 → no overrun, fifo_count stays 4, 8'hA5 appears as the last entry.
- Reset mid-frame: assert rst while in RECV → busy=0, fifo_count=0, all error flags 0; after release with rx_enable=1, the next good frame is received normally.
